// File: rtl/pattern_evt_pkg.sv
// Shared types and helper functions for the pattern event window counter.
package pattern_evt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } evt_state_t;

    // Timer must hold WIN_LEN-2; never narrower than one bit.
    function automatic int tmr_width(input int win_len);
        int w;
        w = $clog2(win_len - 1);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val,
                                            input logic        en);
        logic [31:0] res;
        if (en && (val < max_val)) begin
            res = val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/evt_edge_det.sv
// Rising-edge detector: registers the level and flags a low-to-high transition.
module evt_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q_r;

    // Previous-cycle copy of the input level.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q_r <= 1'b0;
        end else begin
            d_q_r <= d;
        end
    end

    assign rise = d & ~d_q_r;

endmodule

// File: rtl/pattern_event_window_counter.sv
// Counts detect events in a fixed window, reports on valid/ready and pulses irq on threshold.
// Optional REPORT-phase drop counter enabled by macro PATTERN_EVT_DROP_CNT_EN.
module pattern_event_window_counter
    import pattern_evt_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_in,
    input  logic [CNT_W-1:0] cfg_thresh,
    output logic             irq,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_hit,
    output logic             busy
`ifdef PATTERN_EVT_DROP_CNT_EN
    ,
    input  logic             drop_clr,
    output logic [7:0]       drop_cnt
`endif
);

    localparam int               TMR_W    = tmr_width(WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WIN_LEN - 2);

    evt_state_t       state_r;
    evt_state_t       state_s;
    logic             evt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [CNT_W-1:0] thr_r;
    logic [TMR_W-1:0] timer_r;
    logic             open_s;
    logic             close_s;
    logic             accept_s;
    logic             cross_s;
    logic             irq_r;
    logic             rpt_valid_r;
    logic [CNT_W-1:0] rpt_count_r;
    logic             rpt_hit_r;
    logic             busy_r;

    evt_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (det_in),
        .rise (evt_s)
    );

    // Next-state decode and window open/close/accept strobes.
    always_comb begin
        state_s  = state_r;
        cnt_nx_s = cnt_r;
        open_s   = 1'b0;
        close_s  = 1'b0;
        accept_s = 1'b0;
        cross_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (evt_s) begin
                    state_s = COUNT;
                    open_s  = 1'b1;
                    cross_s = (cfg_thresh == CNT_W'(1'b1));
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                cnt_nx_s = CNT_W'(sat_inc(32'(cnt_r), 32'(CNT_MAX), evt_s));
                // Only the transition from below to at-or-above threshold fires irq.
                cross_s  = (thr_r != {CNT_W{1'b0}}) && (cnt_r < thr_r) && (cnt_nx_s >= thr_r);
                if (timer_r == {TMR_W{1'b0}}) begin
                    state_s = REPORT;
                    close_s = 1'b1;
                end else begin
                    state_s = COUNT;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    state_s  = IDLE;
                    accept_s = 1'b1;
                end else begin
                    state_s = REPORT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, window counter, timer, captured threshold and irq/busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            timer_r <= {TMR_W{1'b0}};
            thr_r   <= {CNT_W{1'b0}};
            irq_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            irq_r   <= cross_s;
            busy_r  <= (state_s != IDLE);
            if (open_s) begin
                cnt_r   <= CNT_W'(1'b1);
                timer_r <= TMR_LOAD;
                thr_r   <= cfg_thresh;
            end else if (state_r == COUNT) begin
                cnt_r <= cnt_nx_s;
                if (!close_s) begin
                    timer_r <= timer_r - TMR_W'(1'b1);
                end else begin
                    timer_r <= timer_r;
                end
            end else begin
                cnt_r   <= cnt_r;
                timer_r <= timer_r;
            end
        end
    end

    // Report holding registers: captured at window close, held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_valid_r <= 1'b0;
            rpt_count_r <= {CNT_W{1'b0}};
            rpt_hit_r   <= 1'b0;
        end else if (close_s) begin
            rpt_valid_r <= 1'b1;
            rpt_count_r <= cnt_nx_s;
            rpt_hit_r   <= (thr_r != {CNT_W{1'b0}}) && (cnt_nx_s >= thr_r);
        end else if (accept_s) begin
            rpt_valid_r <= 1'b0;
        end else begin
            rpt_valid_r <= rpt_valid_r;
        end
    end

    assign irq       = irq_r;
    assign rpt_valid = rpt_valid_r;
    assign rpt_count = rpt_count_r;
    assign rpt_hit   = rpt_hit_r;
    assign busy      = busy_r;

`ifdef PATTERN_EVT_DROP_CNT_EN
    logic [7:0] drop_cnt_r;

    // Events arriving while a report is pending; clear has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_clr) begin
            drop_cnt_r <= 8'd0;
        end else if (evt_s && (state_r == REPORT)) begin
            drop_cnt_r <= 8'(sat_inc(32'(drop_cnt_r), 32'd255, 1'b1));
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_pattern_event_window_counter.sv
// Bench for pattern_event_window_counter: vector table, corner sequences, random trace vs window model.
module tb_pattern_event_window_counter;

    localparam int WIN  = 16;
    localparam int WIN2 = 64;
    localparam int NR   = 600;

    logic       clk = 1'b0;
    logic       rst, det_in, rpt_ready;
    logic [3:0] cfg_thresh;
    logic       irq, rpt_valid, rpt_hit, busy;
    logic [3:0] rpt_count;
    logic       rst2, det2, rdy2;
    logic [3:0] thr2;
    logic       irq2, valid2, hit2, busy2;
    logic [3:0] count2;
`ifdef PATTERN_EVT_DROP_CNT_EN
    logic       drop_clr, drop_clr2;
    logic [7:0] drop_cnt, drop_cnt2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_event_window_counter #(.WIN_LEN(WIN), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .det_in(det_in), .cfg_thresh(cfg_thresh), .irq(irq),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_count(rpt_count),
        .rpt_hit(rpt_hit), .busy(busy)
`ifdef PATTERN_EVT_DROP_CNT_EN
        , .drop_clr(drop_clr), .drop_cnt(drop_cnt)
`endif
    );

    pattern_event_window_counter #(.WIN_LEN(WIN2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst2), .det_in(det2), .cfg_thresh(thr2), .irq(irq2),
        .rpt_valid(valid2), .rpt_ready(rdy2), .rpt_count(count2),
        .rpt_hit(hit2), .busy(busy2)
`ifdef PATTERN_EVT_DROP_CNT_EN
        , .drop_clr(drop_clr2), .drop_cnt(drop_cnt2)
`endif
    );

    typedef struct {
        int         r0, r1, r2, r3;
        int         width;
        logic [3:0] thr;
        int         exp_rpt, exp_count, exp_hit, exp_irq;
    } vec_t;

    vec_t vecs[7];

    logic det_a[NR];
    logic rdy_a[NR];
    logic [3:0] th_a[NR];
    logic o_irq[NR], o_val[NR], o_busy[NR], o_hit[NR];
    logic [3:0] o_cnt[NR];
    int e_irq[NR+WIN+2], e_val[NR+WIN+2], e_busy[NR+WIN+2], e_cnt[NR+WIN+2], e_hit[NR+WIN+2];

    int first_valid, first_irq, irq_n, cnt_at, hit_at, valid_n;
    int t, h, mcnt, mthr, done, c;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic det_v);
        rst = 1'b1; det_in = det_v; rpt_ready = 1'b1; cfg_thresh = 4'd0;
`ifdef PATTERN_EVT_DROP_CNT_EN
        drop_clr = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic in_pulse(input vec_t v, input int cyc);
        logic res;
        res = 1'b0;
        if (v.r0 >= 0 && cyc >= v.r0 && cyc < v.r0 + v.width) res = 1'b1;
        if (v.r1 >= 0 && cyc >= v.r1 && cyc < v.r1 + v.width) res = 1'b1;
        if (v.r2 >= 0 && cyc >= v.r2 && cyc < v.r2 + v.width) res = 1'b1;
        if (v.r3 >= 0 && cyc >= v.r3 && cyc < v.r3 + v.width) res = 1'b1;
        return res;
    endfunction

    function automatic logic rise_at(input int i);
        return det_a[i] && ((i == 0) || !det_a[i-1]);
    endfunction

    initial begin
        rst2 = 1'b1; det2 = 1'b0; rdy2 = 1'b1; thr2 = 4'd0;
`ifdef PATTERN_EVT_DROP_CNT_EN
        drop_clr2 = 1'b0;
`endif
        vecs[0] = '{r0:10, r1:-1, r2:-1, r3:-1, width:3, thr:4'd3,  exp_rpt:26, exp_count:1, exp_hit:0, exp_irq:-1};
        vecs[1] = '{r0:10, r1:14, r2:25, r3:-1, width:1, thr:4'd3,  exp_rpt:26, exp_count:3, exp_hit:1, exp_irq:26};
        vecs[2] = '{r0:10, r1:14, r2:25, r3:-1, width:1, thr:4'd0,  exp_rpt:26, exp_count:3, exp_hit:0, exp_irq:-1};
        vecs[3] = '{r0:10, r1:-1, r2:-1, r3:-1, width:1, thr:4'd1,  exp_rpt:26, exp_count:1, exp_hit:1, exp_irq:11};
        vecs[4] = '{r0:10, r1:12, r2:14, r3:16, width:1, thr:4'd2,  exp_rpt:26, exp_count:4, exp_hit:1, exp_irq:13};
        vecs[5] = '{r0:10, r1:26, r2:-1, r3:-1, width:1, thr:4'd2,  exp_rpt:26, exp_count:1, exp_hit:0, exp_irq:-1};
        vecs[6] = '{r0:10, r1:12, r2:-1, r3:-1, width:1, thr:4'd15, exp_rpt:26, exp_count:2, exp_hit:0, exp_irq:-1};

        // Table-driven windows, ready always high.
        for (int v = 0; v < 7; v++) begin
            do_reset(1'b0);
            first_valid = -1; first_irq = -1; irq_n = 0; cnt_at = -1; hit_at = -1;
            for (int cy = 0; cy < 45; cy++) begin
                if (rpt_valid && first_valid < 0) begin
                    first_valid = cy; cnt_at = int'(rpt_count); hit_at = int'(rpt_hit);
                end
                if (irq) begin
                    irq_n++;
                    if (first_irq < 0) first_irq = cy;
                end
                det_in = in_pulse(vecs[v], cy); cfg_thresh = vecs[v].thr; rpt_ready = 1'b1;
                tick();
            end
            check($sformatf("vec%0d_rpt_cycle", v), first_valid, vecs[v].exp_rpt);
            check($sformatf("vec%0d_count", v), cnt_at, vecs[v].exp_count);
            check($sformatf("vec%0d_hit", v), hit_at, vecs[v].exp_hit);
            check($sformatf("vec%0d_irq_cycle", v), first_irq, vecs[v].exp_irq);
            check($sformatf("vec%0d_irq_pulses", v), irq_n, (vecs[v].exp_irq >= 0) ? 1 : 0);
        end

        // Reset values after a window left non-zero report data.
        do_reset(1'b0);
        check("reset_irq", int'(irq), 0);
        check("reset_valid", int'(rpt_valid), 0);
        check("reset_count", int'(rpt_count), 0);
        check("reset_hit", int'(rpt_hit), 0);
        check("reset_busy", int'(busy), 0);
`ifdef PATTERN_EVT_DROP_CNT_EN
        check("reset_drop_cnt", int'(drop_cnt), 0);
`endif

        // Backpressure: report held 26..40, events in REPORT dropped, no new window.
        do_reset(1'b0);
        irq_n = 0;
        for (int cy = 0; cy < 56; cy++) begin
            if (irq) irq_n++;
            if (cy >= 26 && cy <= 40) begin
                check($sformatf("bp_valid@%0d", cy), int'(rpt_valid), 1);
                check($sformatf("bp_count@%0d", cy), int'(rpt_count), 1);
                check($sformatf("bp_hit@%0d", cy), int'(rpt_hit), 0);
            end
            if (cy == 41) check("bp_valid_drop", int'(rpt_valid), 0);
            if (cy >= 41) check($sformatf("bp_busy@%0d", cy), int'(busy), 0);
`ifdef PATTERN_EVT_DROP_CNT_EN
            if (cy == 41) check("bp_drop_cnt", int'(drop_cnt), 2);
            if (cy == 42) check("bp_drop_clr", int'(drop_cnt), 0);
            drop_clr = (cy == 41);
`endif
            det_in = (cy == 10) || (cy >= 30 && cy <= 31) || (cy >= 35);
            rpt_ready = (cy >= 40);
            cfg_thresh = 4'd3;
            tick();
        end
        check("bp_no_irq", irq_n, 0);

        // Reset mid-window discards it.
        do_reset(1'b0);
        valid_n = 0; irq_n = 0;
        for (int cy = 0; cy < 45; cy++) begin
            if (cy == 17) check("midrst_busy_before", int'(busy), 1);
            if (cy == 19) begin
                check("midrst_busy", int'(busy), 0);
                check("midrst_valid", int'(rpt_valid), 0);
            end
            if (cy >= 19 && rpt_valid) valid_n++;
            if (cy >= 19 && irq) irq_n++;
            det_in = (cy == 10); cfg_thresh = 4'd1; rpt_ready = 1'b1;
            rst = (cy == 18);
            tick();
        end
        check("midrst_no_report", valid_n, 0);
        check("midrst_no_irq", irq_n, 0);

        // det_in high out of reset opens a window in the first cycle.
        do_reset(1'b1);
        for (int cy = 0; cy < 30; cy++) begin
            if (cy == 1) check("hot_busy", int'(busy), 1);
            if (cy == 15) check("hot_valid_early", int'(rpt_valid), 0);
            if (cy == 16) begin
                check("hot_valid", int'(rpt_valid), 1);
                check("hot_count", int'(rpt_count), 1);
            end
            if (cy >= 17) check($sformatf("hot_idle@%0d", cy), int'(busy), 0);
            det_in = 1'b1; cfg_thresh = 4'd0; rpt_ready = 1'b1;
            tick();
        end
        det_in = 1'b0;

        // Saturation on the 64-cycle instance, threshold 0 then 15.
        for (int pass = 0; pass < 2; pass++) begin
            rst2 = 1'b1; det2 = 1'b0; thr2 = (pass == 0) ? 4'd0 : 4'd15;
            tick(); tick();
            rst2 = 1'b0;
            first_valid = -1; first_irq = -1; irq_n = 0; cnt_at = -1; hit_at = -1;
            for (int cy = 0; cy < 80; cy++) begin
                if (valid2 && first_valid < 0) begin
                    first_valid = cy; cnt_at = int'(count2); hit_at = int'(hit2);
                end
                if (irq2) begin
                    irq_n++;
                    if (first_irq < 0) first_irq = cy;
                end
                det2 = (cy < 40) && (cy % 2 == 0); rdy2 = 1'b1;
                tick();
            end
            check($sformatf("sat%0d_rpt_cycle", pass), first_valid, 64);
            check($sformatf("sat%0d_count", pass), cnt_at, 15);
            check($sformatf("sat%0d_hit", pass), hit_at, pass);
            check($sformatf("sat%0d_irq_pulses", pass), irq_n, pass);
            check($sformatf("sat%0d_irq_cycle", pass), first_irq, (pass == 0) ? -1 : 29);
        end

        // Random trace, checked against a window-level model afterwards.
        do_reset(1'b0);
        for (int cy = 0; cy < NR; cy++) begin
            o_irq[cy] = irq; o_val[cy] = rpt_valid; o_busy[cy] = busy;
            o_cnt[cy] = rpt_count; o_hit[cy] = rpt_hit;
            if (cy < NR - WIN - 8) begin
                det_a[cy] = ($urandom_range(0, 9) < 4);
                rdy_a[cy] = ($urandom_range(0, 1) == 1);
            end else begin
                det_a[cy] = 1'b0;
                rdy_a[cy] = 1'b1;
            end
            th_a[cy] = 4'($urandom_range(0, 6));
            det_in = det_a[cy]; rpt_ready = rdy_a[cy]; cfg_thresh = th_a[cy];
            tick();
        end

        for (int i = 0; i < NR + WIN + 2; i++) begin
            e_irq[i] = 0; e_val[i] = 0; e_busy[i] = 0; e_cnt[i] = 0; e_hit[i] = 0;
        end
        c = 0;
        while (c < NR) begin
            if (rise_at(c)) begin
                t = c; mcnt = 0; mthr = int'(th_a[t]); done = 0;
                for (int k = 0; k < WIN; k++) begin
                    if (rise_at(t + k)) mcnt = (mcnt < 15) ? mcnt + 1 : mcnt;
                    if (done == 0 && mthr != 0 && mcnt >= mthr) begin
                        e_irq[t + k + 1] = 1;
                        done = 1;
                    end
                end
                h = t + WIN;
                while (h < NR && !rdy_a[h]) h++;
                for (int x = t + 1; x <= h; x++) e_busy[x] = 1;
                for (int x = t + WIN; x <= h; x++) begin
                    e_val[x] = 1; e_cnt[x] = mcnt;
                    e_hit[x] = (mthr != 0 && mcnt >= mthr) ? 1 : 0;
                end
                c = h + 1;
            end else begin
                c++;
            end
        end

        for (int cy = 0; cy < NR; cy++) begin
            check($sformatf("rnd_irq@%0d", cy), int'(o_irq[cy]), e_irq[cy]);
            check($sformatf("rnd_valid@%0d", cy), int'(o_val[cy]), e_val[cy]);
            check($sformatf("rnd_busy@%0d", cy), int'(o_busy[cy]), e_busy[cy]);
            if (e_val[cy] == 1) begin
                check($sformatf("rnd_count@%0d", cy), int'(o_cnt[cy]), e_cnt[cy]);
                check($sformatf("rnd_hit@%0d", cy), int'(o_hit[cy]), e_hit[cy]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
